// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline types, MEM/WB register layout and ResultSrc encodings
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;
    localparam logic [1:0] RESULT_IMM  = 2'b11;
    typedef struct packed {
        logic            RegWrite;
        logic [4:0]      Rd;
        logic [1:0]      ResultSrc;
        logic [XLEN-1:0] ALUResult;
        logic [XLEN-1:0] load_data;
        logic [XLEN-1:0] PCPlus4;
        logic [XLEN-1:0] ImmExt;
    } memwb_t;
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } late_wb_t;
endpackage

// File: rtl/mux4.sv
// mux4: four-way select, sel indexes d0..d3
module mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);
    assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/wb_late_fifo.sv
// wb_late_fifo: synchronous FIFO of late writeback entries with occupancy count
module wb_late_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  late_wb_t      din,
    input  logic          pop,
    output late_wb_t      dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    late_wb_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/wb_merge_stage.sv
// wb_merge_stage: merges in-order and late results onto one write port (WB_OUT_REG_EN registers outputs)
module wb_merge_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN         = pipeline_pkg::XLEN,
    parameter int NUM_LATE     = 2,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int PW = NUM_LATE > 1 ? $clog2(NUM_LATE) : 1,
    localparam int WW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  memwb_t                        inputs,
    input  logic [NUM_LATE-1:0]           late_valid,
    input  logic [NUM_LATE-1:0][4:0]      late_rd,
    input  logic [NUM_LATE-1:0][XLEN-1:0] late_data,
    output logic [NUM_LATE-1:0]           late_ready,
    output logic                          RegWriteW,
    output logic [4:0]                    RdW,
    output logic [XLEN-1:0]               ResultW,
    output logic                          stall_req,
    output logic [CW-1:0]                 late_count
);
    logic busy, pop, push, accept, full, empty, found;
    late_wb_t head, din;
    logic [XLEN-1:0] inorder, wr_data;
    logic [4:0] wr_rd;
    logic wr_en;
    logic [PW-1:0] rr_ptr, gnt_idx;
    logic [WW-1:0] wait_cnt;
    mux4 #(.W(XLEN)) u_mux (
        .sel(inputs.ResultSrc), .d0(inputs.ALUResult), .d1(inputs.load_data),
        .d2(inputs.PCPlus4), .d3(inputs.ImmExt), .y(inorder)
    );
    wb_late_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .din(din), .pop(pop),
        .dout(head), .count(late_count), .full(full), .empty(empty)
    );
    assign busy = inputs.RegWrite & (inputs.Rd != 5'd0);
    assign pop  = ~busy & ~empty & ~reset;
    // rr_ptr holds the first channel to consider this cycle
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_LATE; k++) begin
            if (!found && late_valid[(int'(rr_ptr) + k) % NUM_LATE]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NUM_LATE);
            end
        end
    end
    assign accept = found & ~full & ~reset;
    always_comb begin
        late_ready          = '0;
        late_ready[gnt_idx] = accept;
    end
    assign din  = '{rd: late_rd[gnt_idx], data: late_data[gnt_idx]};
    assign push = accept & (din.rd != 5'd0);
    always_comb begin
        wr_en   = busy | pop;
        wr_rd   = busy ? inputs.Rd : pop ? head.rd : 5'd0;
        wr_data = busy ? inorder : pop ? head.data : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
        end else begin
            if (accept) rr_ptr <= PW'((int'(gnt_idx) + 1) % NUM_LATE);
            wait_cnt  <= (~empty & ~pop) ? ((wait_cnt == WW'(STARVE_LIMIT)) ? wait_cnt : wait_cnt + 1'b1) : '0;
            stall_req <= (wait_cnt >= WW'(STARVE_LIMIT - 1)) & ~pop;
        end
    end
`ifdef WB_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            RdW       <= '0;
            ResultW   <= '0;
        end else begin
            RegWriteW <= wr_en;
            RdW       <= wr_rd;
            ResultW   <= wr_data;
        end
    end
`else
    assign RegWriteW = wr_en;
    assign RdW       = wr_rd;
    assign ResultW   = wr_data;
`endif
endmodule

// File: tb/tb_wb_merge_stage.sv
// tb_wb_merge_stage: randomized scoreboard bench against a queue-based reference model
module tb_wb_merge_stage;
    import pipeline_pkg::*;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;
    typedef struct { logic [1:0] ready; int count; bit stall; bit wr; } rec_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } w_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    memwb_t inp = '0;
    logic [1:0] lv = '0;
    logic [1:0][4:0] lrd = '0;
    logic [1:0][31:0] ldata = '0;
    logic [1:0] late_ready;
    logic RegWriteW, stall_req;
    logic [4:0] RdW;
    logic [31:0] ResultW;
    logic [2:0] late_count;
    int total = 0, bad = 0;
    rec_t cq[$];
    w_t wq[$];
    late_wb_t mq[$];
    int m_start = 0, m_wait = 0, acc_ch = -1;
    bit m_stall = 0;
    bit saw_stall = 0;

    wb_merge_stage #(.NUM_LATE(2), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(rst), .inputs(inp), .late_valid(lv), .late_rd(lrd), .late_data(ldata),
        .late_ready(late_ready), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .stall_req(stall_req), .late_count(late_count)
    );
    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endfunction

    function automatic logic [31:0] sel_result(memwb_t m);
        case (m.ResultSrc)
            RESULT_ALU:  return m.ALUResult;
            RESULT_LOAD: return m.load_data;
            RESULT_PC4:  return m.PCPlus4;
            default:     return m.ImmExt;
        endcase
    endfunction

    task automatic step();
        rec_t r;
        w_t w;
        late_wb_t e;
        bit bsy, pp, acc;
        int g, sz;
        bsy = inp.RegWrite && inp.Rd != 0;
        sz  = mq.size();
        pp  = !bsy && sz > 0 && !rst;
        r.wr = bsy || pp;
        if (bsy) begin w.rd = inp.Rd; w.data = sel_result(inp); wq.push_back(w); end
        else if (pp) begin w.rd = mq[0].rd; w.data = mq[0].data; wq.push_back(w); end
        g = -1;
        for (int k = 0; k < 2; k++)
            if (g < 0 && lv[(m_start + k) % 2]) g = (m_start + k) % 2;
        acc = g >= 0 && sz < DEPTH && !rst;
        r.ready = acc ? 2'(1 << g) : 2'b00;
        r.count = sz;
        r.stall = m_stall;
        cq.push_back(r);
        if (rst) begin
            mq.delete();
            m_start = 0; m_wait = 0; m_stall = 0;
        end else begin
            m_stall = (m_wait >= LIM - 1) && !pp;
            m_wait  = (sz > 0 && !pp) ? (m_wait < LIM ? m_wait + 1 : m_wait) : 0;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                if (lrd[g] != 0) begin e.rd = lrd[g]; e.data = ldata[g]; mq.push_back(e); end
                m_start = (g + 1) % 2;
            end
        end
        acc_ch = acc ? g : -1;
        @(posedge clk); #1;
    endtask

    task automatic set_busy(bit b);
        inp.ALUResult = $urandom; inp.load_data = $urandom;
        inp.PCPlus4 = $urandom; inp.ImmExt = $urandom;
        inp.ResultSrc = 2'($urandom_range(0, 3));
        if (b) begin inp.RegWrite = 1'b1; inp.Rd = 5'($urandom_range(1, 31)); end
        else if ($urandom_range(0, 1) == 1) begin inp.RegWrite = 1'b0; inp.Rd = 5'($urandom); end
        else begin inp.RegWrite = 1'b1; inp.Rd = 5'd0; end
    endtask

    task automatic offer(int ch, bit allow_zero);
        lv[ch] = 1'b1;
        lrd[ch] = allow_zero ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
        ldata[ch] = $urandom;
    endtask

    task automatic clear_acc();
        if (acc_ch >= 0) lv[acc_ch] = 1'b0;
    endtask

    always @(negedge clk) begin
        rec_t r;
        w_t w;
        if (cq.size() > 0) begin
            r = cq.pop_front();
            chk("late_ready", 64'(late_ready), 64'(r.ready));
            chk("late_count", 64'(late_count), 64'(r.count));
            chk("stall_req", 64'(stall_req), 64'(r.stall));
            if (stall_req) saw_stall = 1;
`ifndef WB_OUT_REG_EN
            chk("RegWriteW", 64'(RegWriteW), 64'(r.wr));
`endif
        end
        if (RegWriteW === 1'b1) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write got rd=%0d data=%h exp=none", RdW, ResultW);
            end else begin
                w = wq.pop_front();
                chk("RdW", 64'(RdW), 64'(w.rd));
                chk("ResultW", 64'(ResultW), 64'(w.data));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        // in-order load result
        set_busy(1); inp.Rd = 5'd5; inp.ResultSrc = RESULT_LOAD; inp.load_data = 32'hDEAD_BEEF;
        step();
        // single late result queued behind busy slots, drained on first free slot
        lv = 2'b01; lrd[0] = 5'd7; ldata[0] = 32'h1234;
        for (int i = 0; i < 3; i++) begin set_busy(1); step(); clear_acc(); end
        set_busy(0); step(); step();
        // both channels contend until full; a freed slot while full must not push
        offer(0, 0); offer(1, 0);
        for (int i = 0; i < 6; i++) begin
            set_busy(1); step();
            if (acc_ch >= 0) offer(acc_ch, 0);
        end
        set_busy(0); step();
        if (acc_ch >= 0) offer(acc_ch, 0);
        set_busy(1); step();
        lv = 2'b00;
        for (int i = 0; i < 6; i++) begin set_busy(0); step(); end
        // starvation with one entry and a continuously busy pipeline
        saw_stall = 0;
        offer(0, 0);
        for (int i = 0; i < 12; i++) begin set_busy(1); step(); clear_acc(); end
        set_busy(0); step();
        set_busy(1); step(); step();
        chk("stall_seen", 64'(saw_stall), 64'd1);
        // rd==0 late entry is acknowledged and dropped
        lv = 2'b10; lrd[1] = 5'd0; ldata[1] = 32'hFFFF_FFFF;
        set_busy(1); step(); clear_acc();
        set_busy(1); step();
        // reset with three queued entries
        for (int i = 0; i < 3; i++) begin offer(0, 0); set_busy(1); step(); clear_acc(); end
        inp.RegWrite = 1'b0; offer(0, 0); offer(1, 0); rst = 1'b1;
        step();
        rst = 1'b0; lv = 2'b00;
        for (int i = 0; i < 4; i++) begin set_busy(0); step(); end
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            set_busy($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 80 : 35));
            for (int c = 0; c < 2; c++)
                if (!lv[c] && $urandom_range(0, 2) == 0) offer(c, 1);
            rst = ($urandom_range(0, 299) == 0);
            step();
            clear_acc();
        end
        rst = 1'b0; lv = 2'b00;
        for (int i = 0; i < DEPTH + 3; i++) begin set_busy(0); step(); end
        @(negedge clk); #1;
        chk("write_queue_drained", 64'(wq.size()), 64'd0);
        chk("model_queue_empty", 64'(mq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
